// File: rtl/ps2_mouse_acc_rd.sv
// PS/2 mouse delta accumulator with a read/acknowledge handshake toward the Saturn peripheral side.
// Saturating signed accumulators, power-of-two sensitivity, clamped reports with residual carry, click-latched buttons.
module ps2_mouse_acc_rd #(
    parameter int unsigned ACC_W    = 12,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned SHIFT    = 0,
    parameter bit          INVERT_Y = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [24:0]      ps2_mouse,
    input  logic             reset_acc,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic             busy,
    output logic [OUT_W-1:0] x,
    output logic [OUT_W-1:0] y,
    output logic             x_sign,
    output logic             y_sign,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [3:0]       buttons
);

    localparam int unsigned SUM_W = ACC_W + 2;
    localparam int unsigned REP_W = OUT_W + 1;

    localparam int REP_MAX_I = (1 << OUT_W) - 1;
    localparam int REP_MIN_I = -(1 << OUT_W);
    localparam int ACC_MAX_I = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN_I = -(1 << (ACC_W - 1));

    localparam logic signed [ACC_W-1:0] REP_MAX   = ACC_W'(REP_MAX_I);
    localparam logic signed [ACC_W-1:0] REP_MIN   = ACC_W'(REP_MIN_I);
    localparam logic signed [SUM_W-1:0] ACC_MAX_S = SUM_W'(ACC_MAX_I);
    localparam logic signed [SUM_W-1:0] ACC_MIN_S = SUM_W'(ACC_MIN_I);
    localparam logic signed [ACC_W-1:0] ACC_MAX_A = ACC_W'(ACC_MAX_I);
    localparam logic signed [ACC_W-1:0] ACC_MIN_A = ACC_W'(ACC_MIN_I);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_ACK
    } state_e;

    // 9-bit packet delta; a PS/2 overflow pins it to the extreme of its sign
    function automatic logic signed [SUM_W-1:0] delta_ext(input logic sgn, input logic ovr,
                                                          input logic [7:0] mag);
        logic signed [8:0] d;
        d = signed'({sgn, mag});
        if (ovr) begin
            d = sgn ? 9'sh100 : 9'sh0FF;
        end
        return SUM_W'(d);
    endfunction

    // {clip, report}: scaled accumulator clamped into the reportable range
    function automatic logic [REP_W:0] clamp_rep(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > REP_MAX) begin
            return {1'b1, REP_MAX[REP_W-1:0]};
        end else if (s < REP_MIN) begin
            return {1'b1, REP_MIN[REP_W-1:0]};
        end
        return {1'b0, s[REP_W-1:0]};
    endfunction

    // {saturated, value}: wide sum folded back into the accumulator range
    function automatic logic [ACC_W:0] saturate(input logic signed [SUM_W-1:0] s);
        if (s > ACC_MAX_S) begin
            return {1'b1, ACC_MAX_A};
        end else if (s < ACC_MIN_S) begin
            return {1'b1, ACC_MIN_A};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    state_e                   state_q,   state_d;
    logic                     old_stb_q, old_stb_d;
    logic signed [ACC_W-1:0]  acc_x_q,   acc_x_d;
    logic signed [ACC_W-1:0]  acc_y_q,   acc_y_d;
    logic                     stk_x_q,   stk_x_d;
    logic                     stk_y_q,   stk_y_d;
    logic [2:0]               btn_now_q, btn_now_d;
    logic [2:0]               latch_q,   latch_d;
    logic [OUT_W-1:0]         x_q,       x_d;
    logic [OUT_W-1:0]         y_q,       y_d;
    logic                     x_sign_q,  x_sign_d;
    logic                     y_sign_q,  y_sign_d;
    logic                     x_ovf_q,   x_ovf_d;
    logic                     y_ovf_q,   y_ovf_d;
    logic [3:0]               buttons_q, buttons_d;
    logic                     rd_ack_q,  rd_ack_d;
    logic                     busy_q,    busy_d;

    logic                     strobe;
    logic                     snap;
    logic signed [SUM_W-1:0]  add_x, add_y;
    logic signed [SUM_W-1:0]  sub_x, sub_y;
    logic signed [SUM_W-1:0]  sum_x, sum_y;
    logic signed [REP_W-1:0]  rep_x, rep_y;
    logic                     clip_x, clip_y;
    logic signed [ACC_W-1:0]  acc_x_n, acc_y_n;
    logic                     sat_x, sat_y;
    logic                     ovf_x, ovf_y;

    logic                     ps2_unused;
    assign ps2_unused = ps2_mouse[3];

    always_comb begin
        state_d   = state_q;
        old_stb_d = ps2_mouse[24];
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        stk_x_d   = stk_x_q;
        stk_y_d   = stk_y_q;
        btn_now_d = btn_now_q;
        latch_d   = latch_q;
        x_d       = x_q;
        y_d       = y_q;
        x_sign_d  = x_sign_q;
        y_sign_d  = y_sign_q;
        x_ovf_d   = x_ovf_q;
        y_ovf_d   = y_ovf_q;
        buttons_d = buttons_q;
        rd_ack_d  = 1'b0;

        strobe = ps2_mouse[24] ^ old_stb_q;
        snap   = (state_q == ST_SNAP);

        {clip_x, rep_x} = clamp_rep(acc_x_q);
        {clip_y, rep_y} = clamp_rep(acc_y_q);

        add_x = '0;
        add_y = '0;
        if (strobe) begin
            add_x = delta_ext(ps2_mouse[4], ps2_mouse[6], ps2_mouse[15:8]);
            add_y = INVERT_Y ? -delta_ext(ps2_mouse[5], ps2_mouse[7], ps2_mouse[23:16])
                             :  delta_ext(ps2_mouse[5], ps2_mouse[7], ps2_mouse[23:16]);
        end

        // Reported amount leaves the accumulator; the remainder stays as residual
        sub_x = '0;
        sub_y = '0;
        if (snap) begin
            sub_x = SUM_W'(rep_x) <<< SHIFT;
            sub_y = SUM_W'(rep_y) <<< SHIFT;
        end

        sum_x = SUM_W'(acc_x_q) + add_x - sub_x;
        sum_y = SUM_W'(acc_y_q) + add_y - sub_y;
        {sat_x, acc_x_n} = saturate(sum_x);
        {sat_y, acc_y_n} = saturate(sum_y);
        ovf_x = (strobe & ps2_mouse[6]) | sat_x;
        ovf_y = (strobe & ps2_mouse[7]) | sat_y;

        case (state_q)
            ST_IDLE: if (rd_req) state_d = ST_SNAP;
            ST_SNAP: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (strobe) begin
            btn_now_d = ps2_mouse[2:0];
        end

        if (reset_acc) begin
            acc_x_d = '0;
            acc_y_d = '0;
            stk_x_d = 1'b0;
            stk_y_d = 1'b0;
            latch_d = '0;
        end else begin
            acc_x_d = acc_x_n;
            acc_y_d = acc_y_n;
            if (snap) begin
                x_d       = rep_x[OUT_W-1:0];
                y_d       = rep_y[OUT_W-1:0];
                x_sign_d  = rep_x[REP_W-1];
                y_sign_d  = rep_y[REP_W-1];
                x_ovf_d   = clip_x | stk_x_q;
                y_ovf_d   = clip_y | stk_y_q;
                buttons_d = {1'b0, btn_now_q | latch_q};
                rd_ack_d  = 1'b1;
                // Sticky and click latch restart with only what arrived in this cycle
                stk_x_d   = ovf_x;
                stk_y_d   = ovf_y;
                latch_d   = strobe ? ps2_mouse[2:0] : 3'b000;
            end else begin
                stk_x_d = stk_x_q | ovf_x;
                stk_y_d = stk_y_q | ovf_y;
                if (strobe) begin
                    latch_d = latch_q | ps2_mouse[2:0];
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            old_stb_q <= ps2_mouse[24];
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            stk_x_q   <= 1'b0;
            stk_y_q   <= 1'b0;
            btn_now_q <= '0;
            latch_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            x_sign_q  <= 1'b0;
            y_sign_q  <= 1'b0;
            x_ovf_q   <= 1'b0;
            y_ovf_q   <= 1'b0;
            buttons_q <= '0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            old_stb_q <= old_stb_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            stk_x_q   <= stk_x_d;
            stk_y_q   <= stk_y_d;
            btn_now_q <= btn_now_d;
            latch_q   <= latch_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_sign_q  <= x_sign_d;
            y_sign_q  <= y_sign_d;
            x_ovf_q   <= x_ovf_d;
            y_ovf_q   <= y_ovf_d;
            buttons_q <= buttons_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign rd_ack  = rd_ack_q;
    assign busy    = busy_q;
    assign x       = x_q;
    assign y       = y_q;
    assign x_sign  = x_sign_q;
    assign y_sign  = y_sign_q;
    assign x_ovf   = x_ovf_q;
    assign y_ovf   = y_ovf_q;
    assign buttons = buttons_q;

endmodule
